mem_responder: RTL

Single-port register-file responder for the 6-bit `addr` / `wr` / `en` bus that the stimulus generator drives on rising `clk` edges. It stores 64 bytes, performs one access per enabled cycle, and returns read data after a fixed, parameterised latency with a valid strobe. It also keeps saturating access counters for the scoreboard. It sits at the far end of the bus as the device under test for address/control stimulus.

---
 rtl/mem_resp_pkg.sv | 18 +
 rtl/mem_responder_if.sv | 24 ++
 rtl/mem_resp_rd_pipe.sv | 37 +++
 rtl/mem_responder.sv | 63 ++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and defaults for the mem_responder register-file responder.
package mem_resp_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_WRITE,
    OP_READ
  } op_e;

  typedef struct packed {
    logic                  v;
    logic [DATA_W_DEF-1:0] d;
  } rd_slot_t;

endpackage

// File: rtl/mem_responder_if.sv
// Access bus between the stimulus generator (master) and the responder (slave).
interface mem_responder_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) ();

  logic              en;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;

  modport master (
    output en, wr, addr, wdata,
    input  rdata, rvalid
  );

  modport slave (
    input  en, wr, addr, wdata,
    output rdata, rvalid
  );

endinterface

// File: rtl/mem_resp_rd_pipe.sv
// RD_LAT-deep (valid, data) shift register carrying read results to the bus.
// Data stages only load alongside a valid, so the output data holds between reads.
module mem_resp_rd_pipe #(
  parameter int RD_LAT = 1,  // legal values: 1 and 2
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_v,
  input  logic [DATA_W-1:0] in_d,
  output logic              out_v,
  output logic [DATA_W-1:0] out_d
);

  logic [RD_LAT-1:0] v;
  logic [DATA_W-1:0] d [RD_LAT];

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the pre-edge value of its neighbour, giving a true shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      for (int i = 0; i < RD_LAT; i++) d[i] <= '0;
    end else begin
      v[0] <= in_v;
      if (in_v) d[0] <= in_d;
      for (int i = 1; i < RD_LAT; i++) begin
        v[i] <= v[i-1];
        if (v[i-1]) d[i] <= d[i-1];
      end
    end
  end

  assign out_v = v[RD_LAT-1];
  assign out_d = d[RD_LAT-1];

endmodule

// File: rtl/mem_responder.sv
// Single-port 2**ADDR_W x DATA_W register file with fixed-latency reads
// and saturating write/read access counters.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_responder_if.slave   bus,
  output logic [CNT_W-1:0] wr_cnt,
  output logic [CNT_W-1:0] rd_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  op_e               op;

  // NOTE: a combinational block assigns a default first so no path can
  // leave op unassigned and infer a latch.
  always_comb begin
    op = OP_IDLE;
    if (bus.en) op = bus.wr ? OP_WRITE : OP_READ;
  end

  // NOTE: the array is reset because cleared contents are architecturally
  // visible; this makes it flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (op == OP_WRITE) begin
      mem[bus.addr] <= bus.wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (op == OP_WRITE && wr_cnt != {CNT_W{1'b1}}) wr_cnt <= wr_cnt + 1'b1;
      if (op == OP_READ  && rd_cnt != {CNT_W{1'b1}}) rd_cnt <= rd_cnt + 1'b1;
    end
  end

  // Stage 0 samples the pre-edge array, so a read sees writes from earlier cycles only.
  mem_resp_rd_pipe #(
    .RD_LAT (RD_LAT),
    .DATA_W (DATA_W)
  ) u_rd_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .in_v  (op == OP_READ),
    .in_d  (mem[bus.addr]),
    .out_v (bus.rvalid),
    .out_d (bus.rdata)
  );

endmodule
